// File: rtl/sdram_write_sequencer_if.sv
// -----------------------------------------------------------------------------
// sdram_write_sequencer_if
//
// Bundles the sample-input, controller-handshake and status signals of the
// SDRAM write sequencer so they travel as one port.
//
// Signals:
//   DATA_IN[15:0]        sample word from the avionics data path
//   DATA_VALID           push strobe, one word per high cycle
//   STATUS               controller busy (1 = busy, 0 = ready)
//   CMD_OUT[1:0]         0 = idle, 2 = write
//   A_OUT_BANK/ROW/COL   bank / row / column address of the current command
//   D_OUT[15:0]          write data (FIFO head, registered)
//   FIFO_FULL            sample buffer holds FIFO_DEPTH words
//   OVERFLOW             sticky, a word has been dropped
//   DROP_COUNT[15:0]     dropped words, saturating
//   MEM_FULL             address space exhausted (non-wrapping build only)
//   ERROR                sticky, a word was discarded after repeated timeouts
//   WORDS_WRITTEN[23:0]  acknowledged writes, wraps
//
// Modports:
//   master  - the data source / controller side (drives inputs, observes outputs)
//   slave   - the sequencer itself
// -----------------------------------------------------------------------------
interface sdram_write_sequencer_if;
    logic [15:0] DATA_IN;
    logic        DATA_VALID;
    logic        STATUS;
    logic [1:0]  CMD_OUT;
    logic [1:0]  A_OUT_BANK;
    logic [12:0] A_OUT_ROW;
    logic [8:0]  A_OUT_COL;
    logic [15:0] D_OUT;
    logic        FIFO_FULL;
    logic        OVERFLOW;
    logic [15:0] DROP_COUNT;
    logic        MEM_FULL;
    logic        ERROR;
    logic [23:0] WORDS_WRITTEN;

    modport master (
        output DATA_IN, DATA_VALID, STATUS,
        input  CMD_OUT, A_OUT_BANK, A_OUT_ROW, A_OUT_COL, D_OUT,
               FIFO_FULL, OVERFLOW, DROP_COUNT, MEM_FULL, ERROR, WORDS_WRITTEN
    );

    modport slave (
        input  DATA_IN, DATA_VALID, STATUS,
        output CMD_OUT, A_OUT_BANK, A_OUT_ROW, A_OUT_COL, D_OUT,
               FIFO_FULL, OVERFLOW, DROP_COUNT, MEM_FULL, ERROR, WORDS_WRITTEN
    );
endinterface

// File: rtl/sdram_write_sequencer.sv
// -----------------------------------------------------------------------------
// sdram_write_sequencer
//
// Buffers 16-bit sample words in a small FIFO and issues them as linear-address
// write commands (CMD_OUT = 2) to the SDRAM controller, using the controller's
// busy STATUS as handshake. Unacknowledged commands are retried; after
// MAX_RETRY consecutive timeouts the word is discarded and ERROR is set.
//
// Ports:
//   CLK_48MHZ  system clock, rising edge
//   RESET_N    asynchronous active-low reset
//   bus        sdram_write_sequencer_if.slave (data in, handshake, status out)
//
// Parameters:
//   FIFO_DEPTH   sample buffer depth (power of two, >= 2)
//   ACK_TIMEOUT  cycles CMD_OUT is held waiting for STATUS to rise
//   MAX_RETRY    consecutive timeouts before the word is discarded
//   PTR_INIT     value the address pointer takes on reset (normally 0)
//
// Build option:
//   SDRAM_WRAP_EN  defined: pointer wraps 24'hFFFFFF -> 0, MEM_FULL tied 0.
//                  undefined: pointer holds at 24'hFFFFFF, MEM_FULL goes
//                  sticky and no further commands are issued.
// -----------------------------------------------------------------------------
module sdram_write_sequencer #(
    parameter int          FIFO_DEPTH  = 16,
    parameter int          ACK_TIMEOUT = 15,
    parameter int          MAX_RETRY   = 3,
    parameter logic [23:0] PTR_INIT    = 24'h000000
) (
    input  logic                   CLK_48MHZ,
    input  logic                   RESET_N,
    sdram_write_sequencer_if.slave bus
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = $clog2(ACK_TIMEOUT + 1);
    localparam int RW = $clog2(MAX_RETRY + 1);

    localparam logic [CW-1:0] DEPTH_C      = CW'(FIFO_DEPTH);
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(ACK_TIMEOUT - 1);
    localparam logic [RW-1:0] RETRY_LAST   = RW'(MAX_RETRY - 1);
    localparam logic [1:0]    CMD_IDLE     = 2'd0;
    localparam logic [1:0]    CMD_WRITE    = 2'd2;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_DONE = 2'd2
    } state_t;

    state_t state_q, state_d;

    // Sample FIFO
    logic [15:0]   mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_idx_q, rd_idx_q;
    logic [CW-1:0] count_q, count_d;
    logic          full_q;
    logic          fifo_empty;
    logic          push, pop, drop;

    // Command side
    logic [1:0]    cmd_q, cmd_d;
    logic [15:0]   dout_q;
    logic          load_dout;
    logic [23:0]   ptr_q, ptr_d;
    logic          advance;
    logic [TW-1:0] timer_q, timer_d;
    logic [RW-1:0] retry_q, retry_d;
    logic          first_q, first_d;
    logic          issue_blocked;

    // Status
    logic [23:0]   words_q;
    logic          words_inc;
    logic [15:0]   drop_cnt_q;
    logic          ovf_q;
    logic          error_q;
    logic          err_set;

`ifndef SDRAM_WRAP_EN
    logic          mem_full_q, mem_full_d;
`endif

    // A word arriving on a full FIFO is still kept if the head leaves in the
    // same cycle.
    assign fifo_empty = (count_q == '0);
    assign push       = bus.DATA_VALID && (!full_q || pop);
    assign drop       = bus.DATA_VALID && full_q && !pop;
    assign count_d    = count_q + CW'(push) - CW'(pop);

    // ------------------------------------------------------------------
    // Address pointer advance and end-of-space handling
    // ------------------------------------------------------------------
    always_comb begin
        ptr_d = ptr_q;
`ifndef SDRAM_WRAP_EN
        mem_full_d = mem_full_q;
`endif
        if (advance) begin
`ifdef SDRAM_WRAP_EN
            ptr_d = ptr_q + 24'd1;
`else
            if (ptr_q == 24'hFFFFFF) begin
                mem_full_d = 1'b1;
            end else begin
                ptr_d = ptr_q + 24'd1;
            end
`endif
        end
    end

`ifdef SDRAM_WRAP_EN
    assign issue_blocked = 1'b0;
`else
    assign issue_blocked = mem_full_q;
`endif

    // ------------------------------------------------------------------
    // Handshake FSM: next state and command outputs
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        cmd_d     = cmd_q;
        timer_d   = timer_q;
        retry_d   = retry_q;
        first_d   = 1'b0;
        pop       = 1'b0;
        advance   = 1'b0;
        load_dout = 1'b0;
        err_set   = 1'b0;
        words_inc = 1'b0;

        case (state_q)
            IDLE: begin
                if (!fifo_empty && !bus.STATUS && !issue_blocked) begin
                    load_dout = 1'b1;
                    cmd_d     = CMD_WRITE;
                    timer_d   = '0;
                    state_d   = ISSUE;
                end
            end

            ISSUE: begin
                if (bus.STATUS) begin
                    cmd_d   = CMD_IDLE;
                    first_d = 1'b1;
                    state_d = WAIT_DONE;
                end else if (timer_q == TIMEOUT_LAST) begin
                    // Timeout: drop the command; the same head word is
                    // re-issued from IDLE unless the retry budget is spent.
                    cmd_d   = CMD_IDLE;
                    state_d = IDLE;
                    if (retry_q == RETRY_LAST) begin
                        err_set = 1'b1;
                        pop     = 1'b1;
                        advance = 1'b1;
                        retry_d = '0;
                    end else begin
                        retry_d = retry_q + RW'(1);
                    end
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end

            WAIT_DONE: begin
                // Acknowledge bookkeeping happens once, on entry.
                if (first_q) begin
                    pop       = 1'b1;
                    advance   = 1'b1;
                    words_inc = 1'b1;
                    retry_d   = '0;
                end
                if (!bus.STATUS) begin
                    state_d = IDLE;
                end
            end

            default: begin
                cmd_d   = CMD_IDLE;
                state_d = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FIFO storage: no reset so it maps onto block RAM
    // ------------------------------------------------------------------
    always_ff @(posedge CLK_48MHZ) begin
        if (push) begin
            mem_q[wr_idx_q] <= bus.DATA_IN;
        end
    end

    // ------------------------------------------------------------------
    // State and status registers
    // ------------------------------------------------------------------
    always_ff @(posedge CLK_48MHZ or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q    <= IDLE;
            cmd_q      <= CMD_IDLE;
            timer_q    <= '0;
            retry_q    <= '0;
            first_q    <= 1'b0;
            wr_idx_q   <= '0;
            rd_idx_q   <= '0;
            count_q    <= '0;
            full_q     <= 1'b0;
            dout_q     <= '0;
            ptr_q      <= PTR_INIT;
            words_q    <= '0;
            drop_cnt_q <= '0;
            ovf_q      <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cmd_q   <= cmd_d;
            timer_q <= timer_d;
            retry_q <= retry_d;
            first_q <= first_d;
            ptr_q   <= ptr_d;
            count_q <= count_d;
            full_q  <= (count_d == DEPTH_C);
            if (push) begin
                wr_idx_q <= wr_idx_q + AW'(1);
            end
            if (pop) begin
                rd_idx_q <= rd_idx_q + AW'(1);
            end
            // Registered read of the FIFO head as the command is launched.
            if (load_dout) begin
                dout_q <= mem_q[rd_idx_q];
            end
            if (words_inc) begin
                words_q <= words_q + 24'd1;
            end
            if (drop) begin
                ovf_q <= 1'b1;
                if (drop_cnt_q != 16'hFFFF) begin
                    drop_cnt_q <= drop_cnt_q + 16'd1;
                end
            end
            if (err_set) begin
                error_q <= 1'b1;
            end
        end
    end

`ifndef SDRAM_WRAP_EN
    always_ff @(posedge CLK_48MHZ or negedge RESET_N) begin
        if (!RESET_N) begin
            mem_full_q <= 1'b0;
        end else begin
            mem_full_q <= mem_full_d;
        end
    end
`endif

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.CMD_OUT       = cmd_q;
    assign bus.A_OUT_BANK    = ptr_q[23:22];
    assign bus.A_OUT_ROW     = ptr_q[21:9];
    assign bus.A_OUT_COL     = ptr_q[8:0];
    assign bus.D_OUT         = dout_q;
    assign bus.FIFO_FULL     = full_q;
    assign bus.OVERFLOW      = ovf_q;
    assign bus.DROP_COUNT    = drop_cnt_q;
    assign bus.ERROR         = error_q;
    assign bus.WORDS_WRITTEN = words_q;
`ifdef SDRAM_WRAP_EN
    assign bus.MEM_FULL      = 1'b0;
`else
    assign bus.MEM_FULL      = mem_full_q;
`endif

endmodule

// File: tb/tb_sdram_write_sequencer.sv
// -----------------------------------------------------------------------------
// tb_sdram_write_sequencer
//
// Scoreboard bench for sdram_write_sequencer. Accepted words are queued by the
// stimulus side; a controller/monitor process acknowledges write commands and
// compares each against the queue head and a simple address counter.
// A second instance, reset to the top of the address space, covers the
// end-of-space behaviour.
// -----------------------------------------------------------------------------
module tb_sdram_write_sequencer;
    localparam int DEPTH   = 16;
    localparam int TMO     = 15;
    localparam int RETRIES = 3;

    localparam int M_ACK   = 0;   // controller acknowledges every command
    localparam int M_NOACK = 1;   // controller never answers (STATUS = 0)
    localparam int M_HOLD  = 2;   // controller busy (STATUS = 1)

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    sdram_write_sequencer_if bus();
    sdram_write_sequencer_if bus_end();

    sdram_write_sequencer #(
        .FIFO_DEPTH (DEPTH),
        .ACK_TIMEOUT(TMO),
        .MAX_RETRY  (RETRIES)
    ) dut (
        .CLK_48MHZ(clk),
        .RESET_N  (rst_n),
        .bus      (bus)
    );

    sdram_write_sequencer #(
        .FIFO_DEPTH (DEPTH),
        .ACK_TIMEOUT(TMO),
        .MAX_RETRY  (RETRIES),
        .PTR_INIT   (24'hFFFFFF)
    ) dut_end (
        .CLK_48MHZ(clk),
        .RESET_N  (rst_n),
        .bus      (bus_end)
    );

    int          total = 0;
    int          bad = 0;
    int          ctrl_mode = M_NOACK;
    bit          ack_rand = 1'b0;
    logic [15:0] exp_q[$];
    logic [23:0] model_ptr = 24'd0;
    logic [23:0] model_words = 24'd0;
    int          accepted = 0;
    int          completed = 0;
    int          model_drops = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [23:0] addr_main();
        return {bus.A_OUT_BANK, bus.A_OUT_ROW, bus.A_OUT_COL};
    endfunction

    function automatic logic [23:0] addr_end();
        return {bus_end.A_OUT_BANK, bus_end.A_OUT_ROW, bus_end.A_OUT_COL};
    endfunction

    // Reference FIFO: a word is kept while fewer than DEPTH words are pending.
    task automatic push_main(input logic [15:0] d);
        bus.DATA_IN    = d;
        bus.DATA_VALID = 1'b1;
        if (accepted - completed < DEPTH) begin
            exp_q.push_back(d);
            accepted++;
        end else begin
            model_drops++;
        end
        @(posedge clk); #1;
        bus.DATA_VALID = 1'b0;
        $display("push data=0x%04h pending=%0d drops=%0d", d, accepted - completed, model_drops);
    endtask

    task automatic wait_cmd_main(input int limit, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (bus.CMD_OUT == 2'd2) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while (completed < accepted && n < 4000) begin
            @(negedge clk);
            n++;
        end
        check(name, 32'(completed), 32'(accepted));
        repeat (4) @(posedge clk);
        #1;
    endtask

    // Controller model and scoreboard monitor
    initial begin : controller
        int dly;
        int len;
        bus.STATUS = 1'b0;
        forever begin
            @(negedge clk);
            if (ctrl_mode == M_HOLD) begin
                bus.STATUS = 1'b1;
            end else if (ctrl_mode == M_ACK && bus.CMD_OUT == 2'd2) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_cmd", 32'(bus.CMD_OUT), 32'd0);
                end else begin
                    $display("write data=0x%04h addr=0x%06h expect data=0x%04h addr=0x%06h",
                             bus.D_OUT, addr_main(), exp_q[0], model_ptr);
                    check("wr_data", 32'(bus.D_OUT), 32'(exp_q[0]));
                    check("wr_addr", 32'(addr_main()), 32'(model_ptr));
                    void'(exp_q.pop_front());
                end
                dly = ack_rand ? int'($urandom_range(0, 3)) : 0;
                len = ack_rand ? int'($urandom_range(1, 8)) : 8;
                repeat (dly) @(negedge clk);
                bus.STATUS = 1'b1;
                repeat (len) @(negedge clk);
                bus.STATUS = 1'b0;
                model_ptr   = model_ptr + 24'd1;
                model_words = model_words + 24'd1;
                completed++;
            end else begin
                bus.STATUS = 1'b0;
            end
        end
    end

    initial begin : watchdog
        #800000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        bit          ok;
        int          w;
        int          need;
        int          guard;
        logic [15:0] word;

        bus.DATA_IN        = 16'h0;
        bus.DATA_VALID     = 1'b0;
        bus_end.DATA_IN    = 16'h0;
        bus_end.DATA_VALID = 1'b0;
        bus_end.STATUS     = 1'b0;
        ctrl_mode          = M_NOACK;

        // ---------------- reset state ----------------
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_cmd",      32'(bus.CMD_OUT), 32'd0);
        check("rst_addr",     32'(addr_main()), 32'd0);
        check("rst_dout",     32'(bus.D_OUT), 32'd0);
        check("rst_full",     32'(bus.FIFO_FULL), 32'd0);
        check("rst_ovf",      32'(bus.OVERFLOW), 32'd0);
        check("rst_drops",    32'(bus.DROP_COUNT), 32'd0);
        check("rst_memfull",  32'(bus.MEM_FULL), 32'd0);
        check("rst_error",    32'(bus.ERROR), 32'd0);
        check("rst_words",    32'(bus.WORDS_WRITTEN), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // ---------------- three words, latency ----------------
        ctrl_mode = M_ACK;
        push_main(16'h00A1);
        @(negedge clk);
        check("lat_cycle1", 32'(bus.CMD_OUT), 32'd0);
        @(negedge clk);
        check("lat_cycle2", 32'(bus.CMD_OUT), 32'd2);
        @(posedge clk); #1;
        push_main(16'h00A2);
        push_main(16'h00A3);
        wait_drain("drain_abc");
        check("abc_words", 32'(bus.WORDS_WRITTEN), 32'(model_words));
        check("abc_col",   32'(bus.A_OUT_COL), 32'(model_ptr[8:0]));

        // ---------------- overflow while controller busy ----------------
        ctrl_mode = M_HOLD;
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 20; i++) begin
            push_main(16'hB000 + 16'(i));
        end
        @(negedge clk);
        check("ovf_full",   32'(bus.FIFO_FULL), 32'(accepted - completed == DEPTH));
        check("ovf_flag",   32'(bus.OVERFLOW), 32'(model_drops != 0));
        check("ovf_drops",  32'(bus.DROP_COUNT), 32'(model_drops));
        check("ovf_no_cmd", 32'(bus.CMD_OUT), 32'd0);
        @(posedge clk); #1;
        ctrl_mode = M_ACK;
        wait_drain("drain_ovf");
        check("ovf_words",   32'(bus.WORDS_WRITTEN), 32'(model_words));
        check("ovf_unfull",  32'(bus.FIFO_FULL), 32'd0);

        // ---------------- retry / timeout ----------------
        ctrl_mode = M_NOACK;
        @(posedge clk); #1;
        word = 16'($urandom);
        push_main(word);
        for (int k = 0; k < RETRIES; k++) begin
            wait_cmd_main(40, ok);
            check("retry_issue", 32'(ok), 32'd1);
            check("retry_data",  32'(bus.D_OUT), 32'(exp_q[0]));
            check("retry_addr",  32'(addr_main()), 32'(model_ptr));
            w = 0;
            while (bus.CMD_OUT == 2'd2 && w < 100) begin
                @(negedge clk);
                w++;
            end
            $display("retry attempt=%0d width=%0d error=%0d", k, w, bus.ERROR);
            check("retry_width", 32'(w), 32'(TMO));
            check("retry_error", 32'(bus.ERROR), 32'(k == RETRIES - 1));
        end
        void'(exp_q.pop_front());
        completed++;
        model_ptr = model_ptr + 24'd1;
        w = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.CMD_OUT == 2'd2) w++;
        end
        check("retry_no_reissue", 32'(w), 32'd0);
        check("retry_ptr",        32'(addr_main()), 32'(model_ptr));
        check("retry_words",      32'(bus.WORDS_WRITTEN), 32'(model_words));
        @(posedge clk); #1;

        // ---------------- random stream up to the row boundary ----------------
        ctrl_mode = M_ACK;
        ack_rand  = 1'b1;
        need  = int'(24'h000200) - int'(model_ptr);
        guard = 0;
        while (need > 0 && guard < 40000) begin
            if (accepted - completed < DEPTH - 2 && $urandom_range(0, 2) != 0) begin
                push_main(16'($urandom));
                need--;
            end else begin
                @(posedge clk); #1;
            end
            guard++;
        end
        check("rand_stimulus_done", 32'(need), 32'd0);
        wait_drain("drain_rand");
        check("bound_col",   32'(bus.A_OUT_COL), 32'd0);
        check("bound_row",   32'(bus.A_OUT_ROW), 32'd1);
        check("bound_bank",  32'(bus.A_OUT_BANK), 32'd0);
        check("rand_words",  32'(bus.WORDS_WRITTEN), 32'(model_words));

        // ---------------- end of address space (second instance) ----------------
        bus_end.DATA_IN    = 16'h0E1E;
        bus_end.DATA_VALID = 1'b1;
        @(posedge clk); #1;
        bus_end.DATA_VALID = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus_end.CMD_OUT == 2'd2) begin
                ok = 1'b1;
                break;
            end
        end
        $display("end write seen=%0d data=0x%04h addr=0x%06h", ok, bus_end.D_OUT, addr_end());
        check("end_issue", 32'(ok), 32'd1);
        check("end_addr",  32'(addr_end()), 32'hFFFFFF);
        check("end_data",  32'(bus_end.D_OUT), 32'h0E1E);
        bus_end.STATUS = 1'b1;
        repeat (3) @(negedge clk);
        bus_end.STATUS = 1'b0;
        repeat (4) @(negedge clk);
        check("end_words", 32'(bus_end.WORDS_WRITTEN), 32'd1);
`ifdef SDRAM_WRAP_EN
        check("end_addr_after", 32'(addr_end()), 32'd0);
        check("end_memfull",    32'(bus_end.MEM_FULL), 32'd0);
`else
        check("end_addr_after", 32'(addr_end()), 32'hFFFFFF);
        check("end_memfull",    32'(bus_end.MEM_FULL), 32'd1);
`endif
        @(posedge clk); #1;
        bus_end.DATA_IN    = 16'h0E2E;
        bus_end.DATA_VALID = 1'b1;
        @(posedge clk); #1;
        bus_end.DATA_VALID = 1'b0;
        w = 0;
        repeat (10) begin
            @(negedge clk);
            if (bus_end.CMD_OUT == 2'd2) w++;
        end
`ifdef SDRAM_WRAP_EN
        check("end_next_cmd", 32'(w != 0), 32'd1);
`else
        check("end_next_cmd", 32'(w), 32'd0);
`endif
        @(posedge clk); #1;

        // ---------------- asynchronous reset during ISSUE ----------------
        ctrl_mode = M_NOACK;
        push_main(16'h5A5A);
        wait_cmd_main(10, ok);
        check("rst_issue_seen", 32'(ok), 32'd1);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("rst_async_cmd", 32'(bus.CMD_OUT), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("post_cmd",     32'(bus.CMD_OUT), 32'd0);
        check("post_addr",    32'(addr_main()), 32'd0);
        check("post_dout",    32'(bus.D_OUT), 32'd0);
        check("post_ovf",     32'(bus.OVERFLOW), 32'd0);
        check("post_drops",   32'(bus.DROP_COUNT), 32'd0);
        check("post_error",   32'(bus.ERROR), 32'd0);
        check("post_words",   32'(bus.WORDS_WRITTEN), 32'd0);
        check("post_full",    32'(bus.FIFO_FULL), 32'd0);
        check("post_end_mf",  32'(bus_end.MEM_FULL), 32'd0);
        check("post_end_wds", 32'(bus_end.WORDS_WRITTEN), 32'd0);
        repeat (5) @(negedge clk);
        check("post_idle_cmd", 32'(bus.CMD_OUT), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
